ext_obi_slave_demux: RTL and testbench



---
 rtl/ext_obi_slave_demux.sv | 174 +++++++++++++++++
 tb/tb_ext_obi_slave_demux.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_slave_demux.sv
// Purpose : 1-master to NSLAVE OBI demultiplexer. The master address is decoded against per-slave
//           windows, and unmapped accesses are answered by an internal error responder.
// Latency : request path (decode, s_req_o, m_gnt_o) and response path are combinational; the error
//           response arrives exactly 1 cycle after its grant.
// Backpr. : the grant is withheld while MAX_OUTSTANDING transactions are in flight, and also while a
//           different target still has responses outstanding, which keeps responses in order.
// Ports   : clk_i/rst_ni (async active-low); m_* = master OBI port; s_* = per-slave OBI ports, with
//           addr/we/be/wdata broadcast to every slave; outstanding_o = in-flight count;
//           decerr_cnt_o = saturating count of unmapped accesses; protocol_err_o = sticky flag for a
//           stray slave rvalid.
module ext_obi_slave_demux #(
  parameter int unsigned               NSLAVE          = 2,
  parameter logic [NSLAVE-1:0][31:0]   START_ADDR      = {32'h2010_0000, 32'h2000_0000},
  parameter logic [NSLAVE-1:0][31:0]   END_ADDR        = {32'h2020_0000, 32'h2010_0000},
  parameter int unsigned               MAX_OUTSTANDING = 4,
  parameter logic [31:0]               ERR_RDATA       = 32'hBADACCE5,
  localparam int unsigned              CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // master side
  input  logic                        m_req_i,
  output logic                        m_gnt_o,
  input  logic [31:0]                 m_addr_i,
  input  logic                        m_we_i,
  input  logic [3:0]                  m_be_i,
  input  logic [31:0]                 m_wdata_i,
  output logic                        m_rvalid_o,
  output logic [31:0]                 m_rdata_o,
  output logic                        m_err_o,
  // slave side
  output logic [NSLAVE-1:0]           s_req_o,
  input  logic [NSLAVE-1:0]           s_gnt_i,
  output logic [31:0]                 s_addr_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_be_o,
  output logic [31:0]                 s_wdata_o,
  input  logic [NSLAVE-1:0]           s_rvalid_i,
  input  logic [NSLAVE-1:0][31:0]     s_rdata_i,
  // status
  output logic [CW-1:0]               outstanding_o,
  output logic [15:0]                 decerr_cnt_o,
  output logic                        protocol_err_o
);

  // Target encoding: 0..NSLAVE-1 are slaves, NSLAVE is the internal error responder.
  localparam int unsigned   TW      = $clog2(NSLAVE + 1);
  localparam logic [TW-1:0] ERR_TGT = TW'(NSLAVE);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [TW-1:0] tgt;
  logic          tgt_is_err;
  logic          tgt_gnt;
  logic          allow;
  logic          hs;

  logic [TW-1:0] cur_tgt_q, cur_tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_pend_q, err_pend_d;
  logic [15:0]   decerr_cnt_q, decerr_cnt_d;
  logic          protocol_err_q, protocol_err_d;

  logic          cur_is_err;
  logic          sel_rvalid;
  logic [31:0]   sel_rdata;
  logic          stray_rvalid;

  // Address decode: iterate downwards so that the lowest matching window wins.
  always_comb begin
    tgt = ERR_TGT;
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if (m_addr_i >= START_ADDR[i] && m_addr_i < END_ADDR[i]) begin
        tgt = TW'(i);
      end
    end
  end

  assign tgt_is_err = (tgt == ERR_TGT);

  // A new target may only be entered once everything in flight has drained.
  assign allow = (cnt_q < CNT_MAX) && ((cnt_q == '0) || (tgt == cur_tgt_q));

  // Request steering. The error responder grants any request immediately.
  always_comb begin
    tgt_gnt = m_req_i;
    s_req_o = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (tgt == TW'(i)) begin
        tgt_gnt    = s_gnt_i[i];
        s_req_o[i] = m_req_i && allow;
      end
    end
  end

  assign m_gnt_o = m_req_i && allow && tgt_gnt;
  assign hs      = m_req_i && m_gnt_o;

  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  // Response selection by the registered target. Any rvalid from a slave that
  // is not the current target, or one arriving with nothing in flight, is stray.
  always_comb begin
    sel_rvalid   = 1'b0;
    sel_rdata    = '0;
    stray_rvalid = 1'b0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (cur_tgt_q == TW'(i)) begin
        sel_rvalid = s_rvalid_i[i];
        sel_rdata  = s_rdata_i[i];
      end else if (s_rvalid_i[i]) begin
        stray_rvalid = 1'b1;
      end
    end
    if ((cnt_q == '0) && (|s_rvalid_i)) begin
      stray_rvalid = 1'b1;
    end
  end

  assign cur_is_err = (cur_tgt_q == ERR_TGT);
  assign m_rvalid_o = cur_is_err ? err_pend_q : (sel_rvalid && (cnt_q != '0));
  assign m_err_o    = cur_is_err && err_pend_q;
  // Read data is forced to zero outside a response so the idle bus is quiet.
  assign m_rdata_o  = !m_rvalid_o ? 32'h0 : (cur_is_err ? ERR_RDATA : sel_rdata);

  always_comb begin
    cur_tgt_d      = hs ? tgt : cur_tgt_q;
    cnt_d          = cnt_q;
    err_pend_d     = err_pend_q;
    decerr_cnt_d   = decerr_cnt_q;
    protocol_err_d = protocol_err_q | stray_rvalid;

    case ({hs, m_rvalid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A new error grant takes priority over consuming the pending error response,
    // so back-to-back error accesses produce back-to-back responses.
    if (hs && tgt_is_err) begin
      err_pend_d = 1'b1;
    end else if (cur_is_err && m_rvalid_o) begin
      err_pend_d = 1'b0;
    end

    if (hs && tgt_is_err && (decerr_cnt_q != 16'hFFFF)) begin
      decerr_cnt_d = decerr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_tgt_q      <= '0;
      cnt_q          <= '0;
      err_pend_q     <= 1'b0;
      decerr_cnt_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      cur_tgt_q      <= cur_tgt_d;
      cnt_q          <= cnt_d;
      err_pend_q     <= err_pend_d;
      decerr_cnt_q   <= decerr_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign outstanding_o  = cnt_q;
  assign decerr_cnt_o   = decerr_cnt_q;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_ext_obi_slave_demux.sv
`timescale 1ns/1ps
module tb_ext_obi_slave_demux;
  localparam int NS   = 2;
  localparam int MAXO = 4;
  localparam logic [31:0] ERRD = 32'hBADACCE5;
  localparam logic [31:0] WST  [NS] = '{32'h2000_0000, 32'h2010_0000};
  localparam logic [31:0] WEN  [NS] = '{32'h2010_0000, 32'h2020_0000};
  // Each slave model answers with addr ^ SALT[j], so a misrouted response shows up as wrong data.
  localparam logic [31:0] SALT [NS] = '{32'h3234_5638, 32'h5A5A_0F0F};

  logic clk = 1'b0;
  logic rst_ni;
  logic m_req_i, m_gnt_o, m_we_i, m_rvalid_o, m_err_o;
  logic [31:0] m_addr_i, m_wdata_i, m_rdata_o;
  logic [3:0] m_be_i;
  logic [NS-1:0] s_req_o, s_gnt_i, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o;
  logic s_we_o;
  logic [3:0] s_be_o;
  logic [NS-1:0][31:0] s_rdata_i;
  logic [2:0] outstanding_o;
  logic [15:0] decerr_cnt_o;
  logic protocol_err_o;

  ext_obi_slave_demux dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .m_err_o(m_err_o), .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .outstanding_o(outstanding_o), .decerr_cnt_o(decerr_cnt_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dat; logic err; } exp_t;
  typedef struct { int rdy; logic [31:0] dat; } sresp_t;

  exp_t   sb [$];
  sresp_t sq [NS][$];
  bit [NS-1:0] presented;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int gnt_pct = 100, dmin = 1, dmax = 1;
  bit inj_rv = 0;
  bit mon_en = 0;
  bit hs_now = 0, hs_err = 0, err_due = 0;
  int model_cnt = 0, exp_decerr = 0, peak_out = 0;
  bit exp_perr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode: lowest window containing the address, -1 when unmapped.
  function automatic int ref_tgt(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= WST[i] && a < WEN[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] b [6];
    int k;
    b = '{32'h1FFF_FFFC, 32'h2000_0000, 32'h200F_FFFC, 32'h2010_0000, 32'h201F_FFFC, 32'h2020_0000};
    k = int'($urandom_range(9));
    if (k < 4)      return WST[0] + ($urandom_range(32'h000F_FFFF) & 32'hFFFF_FFFC);
    else if (k < 8) return WST[1] + ($urandom_range(32'h000F_FFFF) & 32'hFFFF_FFFC);
    else if (k == 8) return 32'h4000_0000 + ($urandom & 32'h0FFF_FFFC);
    else return b[$urandom_range(5)];
  endfunction

  // Slave models: random grants, in-order responses no earlier than one cycle after grant.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int j = 0; j < NS; j++) begin
      s_gnt_i[j] = (int'($urandom_range(99)) < gnt_pct);
      presented[j] = 1'b0;
      if (sq[j].size() > 0)
        if (sq[j][0].rdy <= cyc) presented[j] = 1'b1;
      s_rvalid_i[j] = presented[j];
      s_rdata_i[j]  = presented[j] ? sq[j][0].dat : $urandom;
    end
    s_rvalid_i[1] = s_rvalid_i[1] | inj_rv;
  end

  always @(negedge clk) begin
    for (int j = 0; j < NS; j++) begin
      if (presented[j]) void'(sq[j].pop_front());
      if (s_req_o[j] && s_gnt_i[j])
        sq[j].push_back('{rdy: cyc + int'($urandom_range(dmax, dmin)), dat: s_addr_o ^ SALT[j]});
    end
  end

  // Monitor: pops the scoreboard on every response and tracks in-flight and error counts.
  always @(negedge clk) begin
    int idx;
    logic [NS-1:0] oh;
    exp_t e;
    #2;
    if (mon_en) begin
      if (m_rvalid_o) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_rvalid: got rvalid=1 with data %h, expected no response (t=%0t)", m_rdata_o, $time);
        end else begin
          e = sb.pop_front();
          chk("rdata", m_rdata_o, e.dat);
          chk("rsp_err", 32'(m_err_o), 32'(e.err));
        end
      end
      if (err_due) chk("err_resp_timing", 32'({m_rvalid_o, m_err_o}), 32'h3);
      chk("outstanding", 32'(outstanding_o), 32'(model_cnt));
      chk("decerr_cnt", 32'(decerr_cnt_o), 32'(exp_decerr));
      chk("protocol_err", 32'(protocol_err_o), 32'(exp_perr));
      if (model_cnt == MAXO) chk("gnt_at_max", 32'(m_gnt_o), 32'h0);
      if (m_req_i) begin
        idx = ref_tgt(m_addr_i);
        if (idx < 0) chk("sreq_unmapped", 32'(s_req_o), 32'h0);
        else begin
          oh = '0; oh[idx] = 1'b1;
          chk("sreq_route", 32'(s_req_o == '0 || s_req_o == oh), 32'h1);
          if (m_gnt_o) chk("sreq_on_gnt", 32'(s_req_o), 32'(oh));
        end
        chk("s_addr", s_addr_o, m_addr_i);
        chk("s_wdata", s_wdata_o, m_wdata_i);
        chk("s_we_be", 32'({s_we_o, s_be_o}), 32'({m_we_i, m_be_i}));
      end else chk("sreq_idle", 32'(s_req_o), 32'h0);
      if (int'(outstanding_o) > peak_out) peak_out = int'(outstanding_o);
      model_cnt = model_cnt + int'(hs_now) - int'(m_rvalid_o);
      if (hs_err && exp_decerr != 65535) exp_decerr++;
      err_due = hs_err;
    end
    hs_now = 0;
    hs_err = 0;
  end

  task automatic issue(input logic [31:0] a, output int gc, output int waited);
    bit done;
    int idx;
    exp_t e;
    done = 0; gc = -1; waited = 0;
    idx = ref_tgt(a);
    @(posedge clk); #1;
    m_req_i = 1'b1; m_addr_i = a; m_we_i = 1'($urandom); m_be_i = 4'($urandom); m_wdata_i = $urandom;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (m_gnt_o) begin
        done = 1; gc = cyc;
        e.err = (idx < 0);
        e.dat = ERRD;
        if (idx >= 0) e.dat = a ^ SALT[idx];
        sb.push_back(e);
        hs_now = 1; hs_err = (idx < 0);
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL issue_timeout: addr %h got no grant within 300 cycles, grant required", a);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    m_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      idle_cycle();
      if (sb.size() == 0 && sq[0].size() == 0 && sq[1].size() == 0) begin ok = 1; break; end
    end
    idle_cycle();
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb.size());
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, 32'(m_gnt_o), 32'h0);
    chk({tag, "_rvalid"}, 32'(m_rvalid_o), 32'h0);
    chk({tag, "_rdata"}, m_rdata_o, 32'h0);
    chk({tag, "_err"}, 32'(m_err_o), 32'h0);
    chk({tag, "_sreq"}, 32'(s_req_o), 32'h0);
    chk({tag, "_outstanding"}, 32'(outstanding_o), 32'h0);
    chk({tag, "_decerr"}, 32'(decerr_cnt_o), 32'h0);
    chk({tag, "_perr"}, 32'(protocol_err_o), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, w, g0;
    int gv [5];
    rst_ni = 1'b0; m_req_i = 1'b0; m_addr_i = '0; m_we_i = 1'b0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0; presented = '0;
    #12;
    reset_checks("reset");
    @(negedge clk); #3;
    rst_ni = 1'b1;
    mon_en = 1;

    // Mapped read, response 2 cycles after grant.
    gnt_pct = 100; dmin = 2; dmax = 2;
    issue(32'h2000_0040, gc, w);
    chk("rd_sreq", 32'(s_req_o), 32'h1);
    idle_cycle();
    chk("rd_wait_rvalid", 32'(m_rvalid_o), 32'h0);
    chk("rd_outstanding1", 32'(outstanding_o), 32'h1);
    idle_cycle();
    chk("rd_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("rd_rdata", m_rdata_o, 32'h1234_5678);
    chk("rd_err", 32'(m_err_o), 32'h0);
    idle_cycle();
    chk("rd_outstanding0", 32'(outstanding_o), 32'h0);

    // Unmapped access: immediate grant, error response next cycle.
    issue(32'h3000_0000, gc, w);
    chk("ue_gnt_wait", 32'(w), 32'h0);
    chk("ue_sreq", 32'(s_req_o), 32'h0);
    idle_cycle();
    chk("ue_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("ue_err", 32'(m_err_o), 32'h1);
    chk("ue_rdata", m_rdata_o, ERRD);
    chk("ue_decerr", 32'(decerr_cnt_o), 32'h1);
    idle_cycle();
    chk("ue_rvalid_gone", 32'(m_rvalid_o), 32'h0);

    // Outstanding limit: 5 back-to-back to slave 0 with slow responses.
    dmin = 12; dmax = 12; peak_out = 0;
    for (int k = 0; k < 5; k++) begin
      issue(32'h2000_0100 + 32'(k * 4), gc, w);
      gv[k] = gc;
    end
    chk("max_first4_b2b", 32'(gv[3] - gv[0]), 32'd3);
    chk("max_fifth_after_rsp", 32'(gv[4] - gv[0]), 32'd13);
    drain();
    chk("max_peak", 32'(peak_out), 32'd4);

    // Target switch waits for slave 0 to drain.
    dmin = 2; dmax = 2;
    issue(32'h2000_0200, g0, w);
    @(posedge clk); #1;
    m_addr_i = 32'h2010_0200;
    @(negedge clk);
    chk("sw_sreq_held", 32'(s_req_o), 32'h0);
    chk("sw_gnt_held", 32'(m_gnt_o), 32'h0);
    issue(32'h2010_0200, gc, w);
    chk("sw_gnt_cycle", 32'(gc - g0), 32'd3);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) begin
        gnt_pct = int'($urandom_range(100, 40));
        dmin = 1;
        dmax = int'($urandom_range(5, 1));
      end
      issue(rand_addr(), gc, w);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) idle_cycle();
    end
    drain();

    // Stray rvalid with nothing outstanding.
    #3 inj_rv = 1;
    @(negedge clk);
    chk("pe_no_rvalid", 32'(m_rvalid_o), 32'h0);
    #3 exp_perr = 1; inj_rv = 0;
    repeat (3) @(negedge clk);
    #3 chk("pe_sticky", 32'(protocol_err_o), 32'h1);

    // Reset with 3 outstanding.
    gnt_pct = 100; dmin = 10; dmax = 10;
    for (int k = 0; k < 3; k++) issue(32'h2000_0300 + 32'(k * 4), gc, w);
    idle_cycle();
    chk("rst_pre_outstanding", 32'(outstanding_o), 32'h3);
    mon_en = 0;
    #3 rst_ni = 1'b0;
    #1 reset_checks("midrst");
    repeat (2) @(negedge clk);
    #3 rst_ni = 1'b1;
    for (int t = 0; t < 40 && sq[0].size() > 0; t++) idle_cycle();
    idle_cycle();
    chk("late_rsp_perr", 32'(protocol_err_o), 32'h1);
    chk("late_rsp_outstanding", 32'(outstanding_o), 32'h0);
    sb.delete(); model_cnt = 0; exp_decerr = 0; exp_perr = 1; err_due = 0;
    mon_en = 1;
    dmin = 1; dmax = 3;
    issue(32'h2010_0100, gc, w);
    chk("post_rst_gnt_wait", 32'(w), 32'h0);
    issue(32'h0000_1000, gc, w);
    issue(32'h2000_0010, gc, w);
    drain();
    chk("post_rst_decerr", 32'(decerr_cnt_o), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
